// File: rtl/sevenseg_mux.sv
// Four-digit multiplexed seven-segment driver for a common-anode display.
// Scans digits 0..3, each lit for DIV clocks, with registered active-low seg/an.

module sevenseg_decode (
  input  logic [7:0] code,
  output logic [6:0] glyph
);
  // Active-low a..g; anything above 0x0F shows blank.
  always_comb begin
    glyph = 7'h7F;
    case (code)
      8'h00: glyph = 7'h40;
      8'h01: glyph = 7'h79;
      8'h02: glyph = 7'h24;
      8'h03: glyph = 7'h30;
      8'h04: glyph = 7'h19;
      8'h05: glyph = 7'h12;
      8'h06: glyph = 7'h02;
      8'h07: glyph = 7'h78;
      8'h08: glyph = 7'h00;
      8'h09: glyph = 7'h10;
      8'h0A: glyph = 7'h08;
      8'h0B: glyph = 7'h03;
      8'h0C: glyph = 7'h46;
      8'h0D: glyph = 7'h21;
      8'h0E: glyph = 7'h06;
      8'h0F: glyph = 7'h0E;
      default: glyph = 7'h7F;
    endcase
  end
endmodule

module sevenseg_mux #(
  parameter int DIV   = 50000,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] display_0,
  input  logic [7:0] display_1,
  input  logic [7:0] display_2,
  input  logic [7:0] display_3,
  input  logic [1:0] decplace,
  output logic [7:0] seg,
  output logic [3:0] an
);
  localparam int NUM_DIG = 4;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [NUM_DIG-1:0][7:0] codes;
  logic [NUM_DIG-1:0][6:0] glyph;
  logic [CNT_W-1:0]        presc;
  logic [1:0]              idx;

  assign codes = {display_3, display_2, display_1, display_0};

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    sevenseg_decode u_dec (.code(codes[g]), .glyph(glyph[g]));
  end

  // rstn is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rstn) begin
      presc <= '0;
      idx   <= 2'd0;
      seg   <= 8'hFF;
      an    <= 4'hF;
    end else begin
      if (presc == LAST) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + 1'b1;
      end
      seg <= {(idx != decplace), glyph[idx]};
      an  <= ~(4'b0001 << idx);
    end
  end
endmodule

// File: tb/tb_sevenseg_mux.sv
// Scoreboard bench: stimulus pushes hand-computed seg/an per cycle, monitor
// pops and compares one cycle later. A DIV=5 instance checks scan timing.

module tb_sevenseg_mux;
  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] display_0, display_1, display_2, display_3;
  logic [1:0] decplace;
  logic [7:0] seg4, seg5;
  logic [3:0] an4, an5;

  typedef struct {
    logic [7:0] seg;
    logic [3:0] an;
    int         tid;
  } exp_t;

  exp_t        q[$];
  logic [3:0]  q5[$];
  int          nvec = 0;
  int          nerr = 0;
  int          tid  = 0;

  logic [7:0] glyph_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [3:0] an_tbl [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  always #5 clk = ~clk;

  sevenseg_mux #(.DIV(4), .CNT_W(16)) dut4 (
    .clk(clk), .rstn(rstn),
    .display_0(display_0), .display_1(display_1),
    .display_2(display_2), .display_3(display_3),
    .decplace(decplace), .seg(seg4), .an(an4)
  );

  sevenseg_mux #(.DIV(5), .CNT_W(16)) dut5 (
    .clk(clk), .rstn(rstn),
    .display_0(display_0), .display_1(display_1),
    .display_2(display_2), .display_3(display_3),
    .decplace(decplace), .seg(seg5), .an(an5)
  );

  // Monitor: every cycle with a pending expectation is compared.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      nvec++;
      if (seg4 !== e.seg || an4 !== e.an) begin
        nerr++;
        $display("FAIL t%0d seg/an got %h/%h want %h/%h", e.tid, seg4, an4, e.seg, e.an);
      end
    end
    if (q5.size() > 0) begin
      logic [3:0] a;
      a = q5.pop_front();
      nvec++;
      if (an5 !== a) begin
        nerr++;
        $display("FAIL div5_an got %h want %h", an5, a);
      end
      nvec++;
      if ($countones(~an5) != 1) begin
        nerr++;
        $display("FAIL div5_onehot got an=%h want exactly one low", an5);
      end
    end
  end

  task automatic cyc(input logic [7:0] s, input logic [3:0] a);
    exp_t e;
    e.seg = s; e.an = a; e.tid = tid;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic dwell(input logic [7:0] s, input logic [3:0] a, input int n);
    for (int i = 0; i < n; i++) cyc(s, a);
  endtask

  task automatic rst(input int n);
    rstn = 1'b1;
    repeat (n) cyc(8'hFF, 4'hF);
    rstn = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b1;
    display_0 = 8'h01; display_1 = 8'h02; display_2 = 8'h03; display_3 = 8'h04;
    decplace = 2'd2;
    @(negedge clk);

    // 1: basic scan, dp on digit 2
    tid = 1;
    rst(3);
    dwell(8'hF9, 4'hE, 4);
    dwell(8'hA4, 4'hD, 4);
    dwell(8'h30, 4'hB, 4);
    dwell(8'h99, 4'h7, 4);
    dwell(8'hF9, 4'hE, 2);

    // 2: full hex glyph table on digit 0
    tid = 2;
    decplace = 2'd3;
    for (int c = 0; c < 16; c++) begin
      display_0 = 8'(c);
      rst(1);
      cyc(glyph_tbl[c], 4'hE);
    end

    // 3: blank codes, dp on blank digit and elsewhere
    tid = 3;
    display_0 = 8'h01;
    decplace = 2'd1;
    display_1 = 8'h20;
    rst(1);
    dwell(8'hF9, 4'hE, 4);
    dwell(8'h7F, 4'hD, 4);
    display_1 = 8'hFF;
    rst(1);
    dwell(8'hF9, 4'hE, 4);
    dwell(8'h7F, 4'hD, 4);
    decplace = 2'd0;
    rst(1);
    dwell(8'h79, 4'hE, 4);
    dwell(8'hFF, 4'hD, 4);
    dwell(8'hB0, 4'hB, 4);

    // 4: reset mid-dwell of digit 2 restarts the scan
    tid = 4;
    decplace = 2'd2;
    display_1 = 8'h02;
    rst(1);
    dwell(8'hF9, 4'hE, 4);
    dwell(8'hA4, 4'hD, 4);
    dwell(8'h30, 4'hB, 2);
    rst(1);
    dwell(8'hF9, 4'hE, 4);
    dwell(8'hA4, 4'hD, 1);

    // 5: live input change shows one cycle later
    tid = 5;
    decplace = 2'd3;
    display_0 = 8'h08;
    rst(1);
    dwell(8'h80, 4'hE, 2);
    display_0 = 8'h00;
    dwell(8'hC0, 4'hE, 2);
    cyc(8'hA4, 4'hD);

    // 6: DIV=5 instance, two full frames
    tid = 6;
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    for (int k = 0; k < 40; k++) begin
      q5.push_back(an_tbl[(k / 5) % 4]);
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    nvec++;
    if (q.size() != 0 || q5.size() != 0) begin
      nerr++;
      $display("FAIL drain got %0d/%0d pending want 0/0", q.size(), q5.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/sevenseg_mux.md
Name: sevenseg_mux

Overview:
- Four-digit, time-multiplexed seven-segment display driver for the board's common-anode display.
- Each digit takes an 8-bit code, a 2-bit index selects which digit lights its decimal point, and the block scans the digits in turn.
- It drives registered active-low segment and anode lines.
- It sits beside the command parser and shows the 4-byte firmware version (e.g. "x.yz" style, decimal point on digit 2).

Parameters:
- DIV, 50000, system clock cycles each digit stays lit (≈0.5 ms at 100 MHz). Legal range ≥ 2.
- CNT_W, 16, prescaler counter width. Must satisfy 2^CNT_W ≥ DIV.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rstn  input  1  reset. The name is kept per codebase; polarity is active-high.
- display_0  input  8  code for digit 0 (rightmost, an[0]).
- display_1  input  8  code for digit 1 (an[1]).
- display_2  input  8  code for digit 2 (an[2]).
- display_3  input  8  code for digit 3 (leftmost, an[3]).
- decplace  input  2  index of the digit whose decimal point is lit.
- seg  output  8  active-low segments: seg[0]=a … seg[6]=g, seg[7]=dp.
- an  output  4  active-low digit enables, one-hot-low.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (rstn=1 at a clk edge) sets:
  - prescaler = 0
  - digit index = 0
  - seg = 8'hFF
  - an = 4'hF (all off)
- Reset held mid-scan keeps outputs blank for every cycle it is asserted.
- Prescaler:
  - Increments each cycle.
  - When it equals DIV-1 it wraps to 0 and the digit index advances 0→1→2→3→0.
  - Each digit is therefore enabled for exactly DIV consecutive cycles; a full frame is 4·DIV cycles.
- Outputs are registered: each cycle, seg/an are loaded from the current digit index and inputs.
  - The first cycle after reset release shows digit 0.
  - An input change appears on seg one cycle later, if that digit is selected.
- an = ~(4'b0001 << index). Exactly one anode is low outside reset.
- Digit decode uses code = display_<index>.
  - code 0x00–0x0F → hex glyph. seg[6:0] with dp off (seg[7]=1), as full bytes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
  - code 0x10–0xFF → blank, seg[6:0]=7'h7F.
- Decimal point: seg[7] = 0 when index == decplace, else 1. It applies to blank digits too.
- Inputs are sampled combinationally each cycle; there is no input latching. Values changing mid-frame take effect at once on the selected digit.
- No handshake, no busy/valid signals.

Test Plan:
1. DIV=4, display_0..3=01,02,03,04, decplace=2, reset 3 cycles then release:
   - during reset seg=FF, an=F
   - next 4 cycles an=E, seg=F9
   - then 4 cycles an=D, seg=A4
   - then an=B, seg=30 (dp on)
   - then an=7, seg=99
   - then back to an=E
2. Sweep display_0 over 0x00–0x0F, DIV=4, decplace=3 → seg on an=E matches the 16-entry table exactly.
3. display_1=0x20, 0xFF, decplace=1 → seg=7F (blank, dp lit) while an=D. With decplace=0 → seg=FF.
4. Assert reset while index=2 mid-dwell → seg=FF, an=F next edge. After release, an=E for exactly DIV cycles.
5. Change display_0 from 0x08 to 0x00 while an=E → seg goes 80→C0 one cycle later; an timing unaffected.
6. Long run, DIV=5 → each anode low exactly 5 cycles per 20-cycle frame; never two anodes low simultaneously.
